// File: rtl/native_req_master.sv
`timescale 1ns/1ps
// Initiator for the cache native front-end protocol: buffers producer commands in a
// small FIFO, issues them one at a time and returns a one-cycle response per request.
module native_req_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                valid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                ready,
  input  logic [DATA_W-1:0]   rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_write,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [CNT_W-1:0]    req_cnt
);
  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int ENT_W  = ADDR_W + DATA_W + NBYTES;
  localparam int TO_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic              fifo_empty, fifo_full, push, pop;
  logic [ENT_W-1:0]  head;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NBYTES-1:0] wstrb_q, wstrb_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign push       = cmd_valid & ~fifo_full;
  assign head       = mem_q[rptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= {cmd_addr, cmd_wdata, cmd_wstrb};
    end
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    to_cnt_d      = to_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_write_d   = rsp_write_q;
    rsp_timeout_d = rsp_timeout_q;
    req_cnt_d     = req_cnt_q;
    pop           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop                        = 1'b1;
          state_d                    = S_REQ;
          valid_d                    = 1'b1;
          {addr_d, wdata_d, wstrb_d} = head;
          to_cnt_d                   = '0;
        end
      end
      S_REQ: begin
        // A completion in the last allowed cycle beats the timeout.
        if (ready) begin
          state_d       = S_IDLE;
          valid_d       = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = rdata;
          rsp_write_d   = |wstrb_q;
          rsp_timeout_d = 1'b0;
          req_cnt_d     = req_cnt_q + CNT_W'(1);
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          state_d       = S_IDLE;
          valid_d       = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_write_d   = |wstrb_q;
          rsp_timeout_d = 1'b1;
          req_cnt_d     = req_cnt_q + CNT_W'(1);
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    wptr_d = wptr_q + {{FIFO_AW{1'b0}}, push};
    rptr_d = rptr_q + {{FIFO_AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      valid_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      to_cnt_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      req_cnt_q     <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      to_cnt_q      <= to_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_write_q   <= rsp_write_d;
      rsp_timeout_q <= rsp_timeout_d;
      req_cnt_q     <= req_cnt_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  assign cmd_ready   = ~fifo_full;
  assign valid       = valid_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = ~fifo_empty | (state_q != S_IDLE);
  assign req_cnt     = req_cnt_q;

endmodule
